// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: the fetch-to-issue packet and its width.
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pipe_in_t;

    localparam int PIPE_IN_W = $bits(pipe_in_t);

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO decoupling fetch from the rs_scheduler issue stage.
// Status outputs come from registered count only; deq_data reads storage at head.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  pipe_in_t                   enq_data,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output pipe_in_t                   deq_data,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a transfer fires on a cycle where valid and ready are both
    // high at the rising edge. enq_ready depends only on count, so a full queue
    // never accepts a packet, even while its head is being dequeued.
    pipe_in_t          mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              enq_fire;
    logic              deq_fire;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    // Gating by empty hides stale storage, so the array needs no reset.
    assign deq_data  = empty ? pipe_in_t'('0) : mem[head];

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PW'(1);
            end
            if (deq_fire) begin
                head <= head + PW'(1);
            end
            if (enq_fire && !deq_fire) begin
                count <= count + CW'(1);
            end else if (!enq_fire && deq_fire) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && enq_fire) begin
            mem[tail] <= enq_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner-case sequences and
// random traffic, all checked against a queue-based occupancy model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           flush;
    logic           enq_valid;
    pipe_in_t       enq_data;
    logic           enq_ready;
    logic           deq_valid;
    pipe_in_t       deq_data;
    logic           deq_ready;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // scoreboard: packets expected to be in the queue, oldest first
    logic [63:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        ev;
        logic [63:0] ed;
        logic        dr;
        int          exp_count;
        logic        exp_dv;
        logic [63:0] exp_dd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] pkt(input int n);
        return {32'h0000_1000 + 32'(n * 4), 32'hC0DE_0000 + 32'(n)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic fl, input logic ev,
                                input logic [63:0] ed, input logic dr,
                                input int ec, input logic edv, input logic [63:0] edd);
        vec_t v;
        v.rst = rst; v.fl = fl; v.ev = ev; v.ed = ed; v.dr = dr;
        v.exp_count = ec; v.exp_dv = edv; v.exp_dd = edd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] head;
        int          sz;
        sz   = exp_q.size();
        head = (sz > 0) ? exp_q[0] : 64'd0;
        check({tag, ".count"},     64'(count),     64'(sz));
        check({tag, ".full"},      64'(full),      64'(sz == DEPTH));
        check({tag, ".empty"},     64'(empty),     64'(sz == 0));
        check({tag, ".enq_ready"}, 64'(enq_ready), 64'(sz != DEPTH));
        check({tag, ".deq_valid"}, 64'(deq_valid), 64'(sz != 0));
        check({tag, ".deq_data"},  64'(deq_data),  head);
    endtask

    // driver: apply inputs for one cycle, update the model at the edge,
    // return #1 after the edge so outputs can be sampled
    task automatic drive_cycle(input logic rst, input logic fl, input logic ev,
                               input logic [63:0] ed, input logic dr);
        bit ef;
        bit df;
        reset     = rst;
        flush     = fl;
        enq_valid = ev;
        enq_data  = pipe_in_t'(ed);
        deq_ready = dr;
        ef = ev && (exp_q.size() < DEPTH);
        df = dr && (exp_q.size() > 0);
        @(posedge clk);
        if (!rst || fl) begin
            exp_q.delete();
        end else begin
            if (df) void'(exp_q.pop_front());
            if (ef) exp_q.push_back(ed);
        end
        #1;
    endtask

    task automatic idle();
        drive_cycle(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;

        // reset, fill to full, held fifth packet, then drain with wrap
        vecs.push_back(mk(0, 0, 0, 64'd0,  0, 0, 0, 64'd0));
        vecs.push_back(mk(1, 0, 1, pkt(1), 0, 1, 1, pkt(1)));
        vecs.push_back(mk(1, 0, 1, pkt(2), 0, 2, 1, pkt(1)));
        vecs.push_back(mk(1, 0, 1, pkt(3), 0, 3, 1, pkt(1)));
        vecs.push_back(mk(1, 0, 1, pkt(4), 0, 4, 1, pkt(1)));
        vecs.push_back(mk(1, 0, 1, pkt(5), 0, 4, 1, pkt(1)));
        vecs.push_back(mk(1, 0, 0, 64'd0,  1, 3, 1, pkt(2)));
        vecs.push_back(mk(1, 0, 0, 64'd0,  1, 2, 1, pkt(3)));
        vecs.push_back(mk(1, 0, 1, pkt(5), 1, 2, 1, pkt(4)));
        vecs.push_back(mk(1, 0, 1, pkt(6), 1, 2, 1, pkt(5)));
        vecs.push_back(mk(1, 0, 0, 64'd0,  1, 1, 1, pkt(6)));
        vecs.push_back(mk(1, 0, 0, 64'd0,  1, 0, 0, 64'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].rst, vecs[i].fl, vecs[i].ev, vecs[i].ed, vecs[i].dr);
            check($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d.deq_valid", i), 64'(deq_valid), 64'(vecs[i].exp_dv));
            check($sformatf("vec%0d.deq_data", i), 64'(deq_data), vecs[i].exp_dd);
            check_model($sformatf("vec%0d", i));
        end
        check("fill.full_seen", 64'(vecs[5].exp_count), 64'(DEPTH));

        // empty latency: packet not visible in the cycle it is offered
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b1; enq_data = pipe_in_t'(pkt(7)); deq_ready = 1'b0;
        #1;
        check("lat.pre_deq_valid", 64'(deq_valid), 64'd0);
        check("lat.pre_deq_data",  64'(deq_data),  64'd0);
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(7), 1'b0);
        check("lat.post_deq_valid", 64'(deq_valid), 64'd1);
        check("lat.post_deq_data",  64'(deq_data),  pkt(7));

        // flush with enqueue and dequeue in the same cycle
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(8), 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(9), 1'b0);
        check("flush.pre_count", 64'(count), 64'd3);
        drive_cycle(1'b1, 1'b1, 1'b1, pkt(10), 1'b1);
        check("flush.count", 64'(count), 64'd0);
        check("flush.empty", 64'(empty), 64'd1);
        idle();
        check("flush.not_stored", 64'(count), 64'd0);
        check_model("flush");

        // simultaneous enqueue/dequeue at count 2
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(11), 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(12), 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("simul%0d.head", i), 64'(deq_data), pkt(11 + i));
            drive_cycle(1'b1, 1'b0, 1'b1, pkt(13 + i), 1'b1);
            check($sformatf("simul%0d.count", i), 64'(count), 64'd2);
            check_model($sformatf("simul%0d", i));
        end
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(18), 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(19), 1'b0);
        check("full_deq.pre_count", 64'(count), 64'd4);
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b1; enq_data = pipe_in_t'(pkt(20)); deq_ready = 1'b1;
        #1;
        check("full_deq.enq_ready", 64'(enq_ready), 64'd0);
        drive_cycle(1'b1, 1'b0, 1'b1, pkt(20), 1'b1);
        check("full_deq.count", 64'(count), 64'd3);
        check_model("full_deq");

        // reset mid-operation wins over enqueue
        check("rst_mid.pre_count", 64'(count), 64'd3);
        drive_cycle(1'b0, 1'b0, 1'b1, pkt(21), 1'b1);
        check("rst_mid.count",     64'(count),     64'd0);
        check("rst_mid.deq_valid", 64'(deq_valid), 64'd0);
        check("rst_mid.deq_data",  64'(deq_data),  64'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic        r_fl;
            logic [63:0] r_d;
            r_rst = ($urandom_range(0, 79) != 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            r_d   = {$urandom, $urandom};
            drive_cycle(r_rst, r_fl, 1'($urandom_range(0, 1)), r_d,
                        ($urandom_range(0, 2) != 0));
            check_model($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
